rev_mult_seq: RTL and testbench
===============================

Name: rev_mult_seq

Overview:
- Clocked sequencer for a W-bit reversible array multiplier macro with dual-rail (true/complement) pins.
- Accepts forward (A,B → P,garbage) or backward (P,garbage → A,B) requests over a valid/ready handshake.
- Owns all tristate drivers on the macro pins and inserts a bus-release turnaround on every direction change.
- Adds a round-trip self-check mode: forward pass, then backward pass on the captured result, then compare.

Parameters:
- W, 8, operand width; product is 2W bits.
- GARB_W, (W-1)*W+(W-1), packed garbage width: the W-1 reversible carry rows of W bits, followed by W-1 x_c0 bits (63 when W=8).
- SETTLE_CYC, 2, cycles (≥1) the driven inputs are held before the macro outputs are sampled.
- TURN_CYC, 1, cycles (≥1) with all drivers released when the direction changes.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request valid.
- req_ready  output  1  high only in IDLE.
- req_mode  input  2  0 = forward, 1 = backward, 2 = round-trip; 3 is reserved and treated as 0.
- req_a, req_b  input  W  forward operands.
- req_p  input  2W  backward product.
- req_g  input  GARB_W  backward garbage.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_a, rsp_b  output  W  recovered operands (backward/round-trip).
- rsp_p  output  2W  product (forward/round-trip).
- rsp_g  output  GARB_W  garbage (forward/round-trip).
- rsp_err  output  1  round-trip mismatch.
- core_a, core_a_n, core_b, core_b_n  inout  W  macro operand pins.
- core_p, core_p_n  inout  2W  macro product pins.
- core_g, core_g_n  inout  GARB_W  macro garbage pins.

Behaviour:
- Single outstanding request; capture registers are loaded on the handshake edge.
- States: IDLE, TURN, DRIVE, CAPTURE, RESP. Round-trip mode also uses TURN2, DRIVE2 and CAPTURE2.
- Reset (async): state = IDLE; cur_dir = 0 (forward); all driver enables low, so every core pin is Z immediately; rsp_valid = 0; all rsp_* data = 0; rsp_err = 0.
- IDLE → TURN if the requested direction differs from cur_dir, otherwise IDLE → DRIVE. Round-trip starts forward.
- TURN: all pins Z for TURN_CYC cycles, then cur_dir is updated and the FSM enters DRIVE.
- DRIVE: only the input side of cur_dir is driven, true on x and ~x on x_n; the opposite side is Z. Held for SETTLE_CYC cycles.
- CAPTURE: one cycle, inputs still driven. The output side is registered at the end of this cycle.
  - Forward captures p and g.
  - Backward captures a and b.
- Round-trip: after forward CAPTURE the FSM goes to TURN2 (TURN_CYC), then to DRIVE2, which drives the captured p and g backward. CAPTURE2 compares the recovered a,b with the request a,b and sets rsp_err = 1 on any mismatch. rsp_p/rsp_g keep the forward result.
- RESP: all pins Z; rsp_valid = 1 and all data stable until rsp_ready. Then → IDLE; cur_dir is retained.
- Latency from the accept edge to rsp_valid:
  - Same direction: SETTLE_CYC+2 cycles.
  - Direction change: add TURN_CYC.
  - Round-trip: add SETTLE_CYC+1+TURN_CYC.
- Unused response fields are zeroed: backward clears p/g; forward clears a/b; rsp_err = 0 outside round-trip.
- Contention invariant: the fwd-side and rev-side enables are never both high in any cycle, including across reset assertion.
- Z or X sampled on the output side propagates into rsp_*. No masking.

Decomposition:
- Package rev_mult_pkg holds:
  - the state enum;
  - the mode encodings MODE_FWD/MODE_REV/MODE_RT;
  - the garbage field offsets (row r at r*W, x_c0 at (W-1)*W).
- Sub-module rev_dual_rail_drv #(N): en, val[N] → tri pin[N], pin_n[N] (val/~val when en, else Z). The block instantiates it once per bus.

Test Plan:
- Forward, W=8, a=13, b=11 → rsp_p=0x008F at accept+4 cycles, rsp_err=0, rsp_a=rsp_b=0.
- Backward using the captured p=0x008F and g → rsp_a=13, rsp_b=11. A TURN cycle shows all core pins Z, and latency is 5 cycles.
- Round-trip a=255, b=255 → rsp_p=0xFE01, rsp_err=0. Forcing one core_b bit wrong during DRIVE2 → rsp_err=1.
- Hold rsp_ready=0 for 10 cycles → rsp_valid and data stable, req_ready=0, pins Z. Release → IDLE after one cycle.
- Assert rst mid-DRIVE → same-cycle all pins Z, rsp_valid=0. The next forward request starts with no TURN.
- Back-to-back forward requests, 2 then 3 → rsp_p=6, and no turnaround is inserted.

Source files
------------

// File: rtl/rev_mult_pkg.sv
// Shared encodings for the reversible multiplier sequencer: FSM states, request
// modes and the packed garbage-field layout of the macro.
package rev_mult_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_TURN     = 3'd1;
  localparam logic [2:0] ST_DRIVE    = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;
  localparam logic [2:0] ST_TURN2    = 3'd5;
  localparam logic [2:0] ST_DRIVE2   = 3'd6;
  localparam logic [2:0] ST_CAPTURE2 = 3'd7;

  typedef enum logic [1:0] {
    MODE_FWD  = 2'd0,
    MODE_REV  = 2'd1,
    MODE_RT   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Garbage bus: W-1 carry rows of W bits, then W-1 x_c0 bits.
  function automatic int garb_width(input int w);
    return (w - 1) * w + (w - 1);
  endfunction

  function automatic int garb_row_off(input int w, input int r);
    return r * w;
  endfunction

  function automatic int garb_xc0_off(input int w);
    return (w - 1) * w;
  endfunction

endpackage

// File: rtl/rev_dual_rail_drv.sv
// Dual-rail tristate driver: puts val on pin and ~val on pin_n while enabled,
// otherwise releases both rails.
module rev_dual_rail_drv #(
  parameter int N = 8
) (
  input  logic         en,
  input  logic [N-1:0] val,
  inout  tri   [N-1:0] pin,
  inout  tri   [N-1:0] pin_n
);

  assign pin   = en ? val  : {N{1'bz}};
  assign pin_n = en ? ~val : {N{1'bz}};

endmodule

// File: rtl/rev_mult_seq.sv
// Sequencer for a dual-rail reversible array multiplier macro: forward, backward
// and round-trip requests, with bus turnaround whenever the pin direction flips.
module rev_mult_seq
  import rev_mult_pkg::*;
#(
  parameter int W          = 8,
  parameter int GARB_W     = garb_width(W),
  parameter int SETTLE_CYC = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [W-1:0]      req_a,
  input  logic [W-1:0]      req_b,
  input  logic [2*W-1:0]    req_p,
  input  logic [GARB_W-1:0] req_g,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_a,
  output logic [W-1:0]      rsp_b,
  output logic [2*W-1:0]    rsp_p,
  output logic [GARB_W-1:0] rsp_g,
  output logic              rsp_err,
  inout  tri   [W-1:0]      core_a,
  inout  tri   [W-1:0]      core_a_n,
  inout  tri   [W-1:0]      core_b,
  inout  tri   [W-1:0]      core_b_n,
  inout  tri   [2*W-1:0]    core_p,
  inout  tri   [2*W-1:0]    core_p_n,
  inout  tri   [GARB_W-1:0] core_g,
  inout  tri   [GARB_W-1:0] core_g_n
);

  localparam logic [7:0] TURN_LAST   = 8'(TURN_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [2:0]        state;
  logic              cur_dir;
  logic              dir_q;
  logic              rt_q;
  logic [7:0]        cnt;
  logic [W-1:0]      req_a_q;
  logic [W-1:0]      req_b_q;
  logic [2*W-1:0]    req_p_q;
  logic [GARB_W-1:0] req_g_q;

  logic              drive_phase;
  logic              en_fwd;
  logic              en_rev;
  logic [2*W-1:0]    rev_p;
  logic [GARB_W-1:0] rev_g;

  // Enables decode straight from state so an async reset releases every pin at once.
  assign drive_phase = (state == ST_DRIVE)  || (state == ST_CAPTURE) ||
                       (state == ST_DRIVE2) || (state == ST_CAPTURE2);
  assign en_fwd      = drive_phase && !cur_dir;
  assign en_rev      = drive_phase &&  cur_dir;

  // The second half of a round trip feeds the forward result back into the macro.
  assign rev_p = rt_q ? rsp_p : req_p_q;
  assign rev_g = rt_q ? rsp_g : req_g_q;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur_dir <= 1'b0;
      dir_q   <= 1'b0;
      rt_q    <= 1'b0;
      cnt     <= '0;
      req_a_q <= '0;
      req_b_q <= '0;
      req_p_q <= '0;
      req_g_q <= '0;
      rsp_a   <= '0;
      rsp_b   <= '0;
      rsp_p   <= '0;
      rsp_g   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_a_q <= req_a;
            req_b_q <= req_b;
            req_p_q <= req_p;
            req_g_q <= req_g;
            rt_q    <= (req_mode == MODE_RT);
            dir_q   <= (req_mode == MODE_REV);
            cnt     <= '0;
            state   <= ((req_mode == MODE_REV) != cur_dir) ? ST_TURN : ST_DRIVE;
          end
        end
        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt     <= '0;
            cur_dir <= dir_q;
            state   <= ST_DRIVE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DRIVE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CAPTURE: begin
          if (!cur_dir) begin
            rsp_p <= core_p;
            rsp_g <= core_g;
            rsp_a <= '0;
            rsp_b <= '0;
          end else begin
            rsp_a <= core_a;
            rsp_b <= core_b;
            rsp_p <= '0;
            rsp_g <= '0;
          end
          rsp_err <= 1'b0;
          cnt     <= '0;
          state   <= rt_q ? ST_TURN2 : ST_RESP;
        end
        ST_TURN2: begin
          if (cnt == TURN_LAST) begin
            cnt     <= '0;
            cur_dir <= 1'b1;
            state   <= ST_DRIVE2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DRIVE2: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_CAPTURE2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CAPTURE2: begin
          rsp_a   <= core_a;
          rsp_b   <= core_b;
          rsp_err <= (core_a != req_a_q) || (core_b != req_b_q);
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rev_dual_rail_drv #(.N(W)) u_drv_a (
    .en(en_fwd), .val(req_a_q), .pin(core_a), .pin_n(core_a_n)
  );

  rev_dual_rail_drv #(.N(W)) u_drv_b (
    .en(en_fwd), .val(req_b_q), .pin(core_b), .pin_n(core_b_n)
  );

  rev_dual_rail_drv #(.N(2*W)) u_drv_p (
    .en(en_rev), .val(rev_p), .pin(core_p), .pin_n(core_p_n)
  );

  rev_dual_rail_drv #(.N(GARB_W)) u_drv_g (
    .en(en_rev), .val(rev_g), .pin(core_g), .pin_n(core_g_n)
  );

endmodule

// File: tb/tb_rev_mult_seq.sv
// Self-checking bench for rev_mult_seq: a behavioural macro on pulled-up dual-rail
// pins plus a request-level reference model for results, latency and pin release.
`timescale 1ns/100ps
module tb_rev_mult_seq;
  import rev_mult_pkg::*;

  localparam int W      = 8;
  localparam int GW     = garb_width(W);
  localparam int SETTLE = 2;
  localparam int TURN   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_mode = 2'd0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [2*W-1:0] req_p = '0;
  logic [GW-1:0] req_g = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_a;
  logic [W-1:0]  rsp_b;
  logic [2*W-1:0] rsp_p;
  logic [GW-1:0] rsp_g;
  logic          rsp_err;

  // Released rails read as all ones, so a driven pair is recognisable by pin_n == ~pin.
  tri1 [W-1:0]   core_a, core_a_n, core_b, core_b_n;
  tri1 [2*W-1:0] core_p, core_p_n;
  tri1 [GW-1:0]  core_g, core_g_n;

  int nvec = 0;
  int nmis = 0;
  int model_dir = 0;

  rev_mult_seq #(.W(W), .GARB_W(GW), .SETTLE_CYC(SETTLE), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b), .req_p(req_p), .req_g(req_g),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_p(rsp_p), .rsp_g(rsp_g), .rsp_err(rsp_err),
    .core_a(core_a), .core_a_n(core_a_n), .core_b(core_b), .core_b_n(core_b_n),
    .core_p(core_p), .core_p_n(core_p_n), .core_g(core_g), .core_g_n(core_g_n)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  function automatic logic [GW-1:0] fwd_garb(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [GW-1:0]  g;
    p = mul(x, y);
    g = '0;
    g[garb_row_off(W, 0) +: W] = x ^ p[W-1:0];
    g[garb_row_off(W, 1) +: W] = y ^ p[2*W-1:W];
    for (int r = 2; r < W - 1; r++) g[garb_row_off(W, r) +: W] = x + W'(r);
    g[garb_xc0_off(W) +: W-1] = y[W-2:0];
    return g;
  endfunction

  function automatic logic [W-1:0] back_a(input logic [2*W-1:0] p, input logic [GW-1:0] g);
    return g[garb_row_off(W, 0) +: W] ^ p[W-1:0];
  endfunction

  function automatic logic [W-1:0] back_b(input logic [2*W-1:0] p, input logic [GW-1:0] g);
    return g[garb_row_off(W, 1) +: W] ^ p[2*W-1:W];
  endfunction

  // Behavioural macro: answers whichever side is being driven by the sequencer.
  logic           mac_fwd = 1'b0;
  logic           mac_rev = 1'b0;
  logic [2*W-1:0] mac_p = '0;
  logic [GW-1:0]  mac_g = '0;
  logic [W-1:0]   mac_a = '0;
  logic [W-1:0]   mac_b = '0;
  bit             inj_b = 1'b0;

  assign core_p   = mac_fwd ? mac_p  : 'z;
  assign core_p_n = mac_fwd ? ~mac_p : 'z;
  assign core_g   = mac_fwd ? mac_g  : 'z;
  assign core_g_n = mac_fwd ? ~mac_g : 'z;
  assign core_a   = mac_rev ? mac_a  : 'z;
  assign core_a_n = mac_rev ? ~mac_a : 'z;
  assign core_b   = mac_rev ? mac_b  : 'z;
  assign core_b_n = mac_rev ? ~mac_b : 'z;

  function automatic bit in_side_driven();
    return (core_a_n == ~core_a) && (core_b_n == ~core_b);
  endfunction

  function automatic bit out_side_driven();
    return (core_p_n == ~core_p) && (core_g_n == ~core_g);
  endfunction

  function automatic bit all_released();
    return &{core_a, core_a_n, core_b, core_b_n, core_p, core_p_n, core_g, core_g_n};
  endfunction

  initial begin
    bit nf, nr;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      nf = !mac_rev && in_side_driven();
      nr = !mac_fwd && out_side_driven();
      if (nf) begin
        mac_p = mul(core_a, core_b);
        mac_g = fwd_garb(core_a, core_b);
      end
      if (nr) begin
        mac_a = back_a(core_p, core_g);
        mac_b = back_b(core_p, core_g) ^ {{(W-1){1'b0}}, inj_b};
      end
      mac_fwd = nf;
      mac_rev = nr;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] p, input logic [GW-1:0] g,
                               input int hold, input bit inj);
    logic [W-1:0]   ea, eb, sa, sb;
    logic [2*W-1:0] ep, sp;
    logic [GW-1:0]  eg, sg;
    logic           eerr, serr;
    int             elat, lat;
    bit             rt, tdir, contend, unstable, held_bad;

    rt   = (mode == 2'd2);
    tdir = (mode == 2'd1);
    if (tdir) begin
      ea = back_a(p, g); eb = back_b(p, g); ep = '0; eg = '0; eerr = 1'b0;
    end else begin
      ep = mul(a, b); eg = fwd_garb(a, b); ea = '0; eb = '0; eerr = 1'b0;
      if (rt) begin
        ea = a; eb = b ^ {{(W-1){1'b0}}, inj}; eerr = inj;
      end
    end
    elat = SETTLE + 2 + ((int'(tdir) != model_dir) ? TURN : 0) + (rt ? SETTLE + 1 + TURN : 0);

    @(negedge clk);
    req_valid = 1'b1; req_mode = mode; req_a = a; req_b = b; req_p = p; req_g = g;
    inj_b = inj; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (int'(tdir) != model_dir)
      checkOutput("turn_released", 128'(all_released()), 128'(1));
    model_dir = (rt || tdir) ? 1 : 0;

    contend = 1'b0;
    while (!rsp_valid && lat < 100) begin
      if (in_side_driven() && !mac_rev && out_side_driven() && !mac_fwd) contend = 1'b1;
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_valid", 128'(rsp_valid), 128'(1));
    checkOutput("latency", 128'(lat), 128'(elat));
    checkOutput("contention", 128'(contend), 128'(0));
    checkOutput("rsp_a", 128'(rsp_a), 128'(ea));
    checkOutput("rsp_b", 128'(rsp_b), 128'(eb));
    checkOutput("rsp_p", 128'(rsp_p), 128'(ep));
    checkOutput("rsp_g", 128'(rsp_g), 128'(eg));
    checkOutput("rsp_err", 128'(rsp_err), 128'(eerr));

    sa = rsp_a; sb = rsp_b; sp = rsp_p; sg = rsp_g; serr = rsp_err;
    unstable = 1'b0; held_bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_a !== sa || rsp_b !== sb || rsp_p !== sp ||
          rsp_g !== sg || rsp_err !== serr) unstable = 1'b1;
      if (req_ready !== 1'b0 || !all_released()) held_bad = 1'b1;
    end
    if (hold > 0) begin
      checkOutput("hold_stable", 128'(unstable), 128'(0));
      checkOutput("hold_ready_pins", 128'(held_bad), 128'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    inj_b = 1'b0;
    checkOutput("back_to_idle", 128'({rsp_valid, req_ready}), 128'(2'b01));
  endtask

  task automatic resetMidDrive(input logic [2*W-1:0] p, input logic [GW-1:0] g);
    @(negedge clk);
    req_valid = 1'b1; req_mode = 2'd1; req_p = p; req_g = g;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #0.5;
    checkOutput("rst_drv_released", 128'(&{core_p, core_p_n, core_g, core_g_n}), 128'(1));
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    checkOutput("rst_rsp_a", 128'(rsp_a), 128'(0));
    #2;
    checkOutput("rst_all_released", 128'(all_released()), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    model_dir = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rm;

    repeat (3) @(negedge clk);
    checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    checkOutput("reset_req_ready", 128'(req_ready), 128'(1));
    checkOutput("reset_rsp_p", 128'(rsp_p), 128'(0));
    checkOutput("reset_rsp_err", 128'(rsp_err), 128'(0));
    checkOutput("reset_pins", 128'(all_released()), 128'(1));
    rst = 1'b0;

    applyStimulus(2'd0, 8'd13, 8'd11, '0, '0, 0, 1'b0);
    applyStimulus(2'd1, '0, '0, 16'h008F, fwd_garb(8'd13, 8'd11), 0, 1'b0);
    applyStimulus(2'd2, 8'd255, 8'd255, '0, '0, 0, 1'b0);
    applyStimulus(2'd2, 8'd255, 8'd255, '0, '0, 0, 1'b1);
    applyStimulus(2'd0, 8'd100, 8'd200, '0, '0, 10, 1'b0);
    applyStimulus(2'd1, '0, '0, mul(8'd9, 8'd17), fwd_garb(8'd9, 8'd17), 0, 1'b0);
    resetMidDrive(mul(8'd3, 8'd4), fwd_garb(8'd3, 8'd4));
    applyStimulus(2'd0, 8'd5, 8'd6, '0, '0, 0, 1'b0);
    applyStimulus(2'd0, 8'd7, 8'd9, '0, '0, 0, 1'b0);
    applyStimulus(2'd0, 8'd2, 8'd3, '0, '0, 0, 1'b0);
    applyStimulus(2'd3, 8'd21, 8'd34, '0, '0, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if (rm == 2'd1)
        applyStimulus(rm, '0, '0, mul(ra, rb), fwd_garb(ra, rb), $urandom_range(0, 2), 1'b0);
      else
        applyStimulus(rm, ra, rb, '0, '0, $urandom_range(0, 2),
                      (rm == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
